// File: rtl/reshape_cmd_issuer.sv
// rtl/reshape_cmd_issuer.sv - host command issuer and handshake sequencer for the reshape state machine
// Purpose: accepts one host reshape command at a time, issues its one-hot
//   control code, waits for the reshape state machine to run and reach irq,
//   raises irq to the host, then drives the release code until Next_Reg.
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   cmd_valid, cmd_op     host command (0 concat, 1 split, 2 maxpool, 3 upsample)
//   cmd_ready             command accept, high only in IDLE
//   Control_Reshape       registered control word to the reshape state machine
//   State, Next_Reg       state code and irq-exit pulse from the reshape state machine
//   irq, irq_clr          level interrupt to host and its clear
//   busy, done_cnt, err   status: not idle, completed operations, sticky watchdog error
// Build option: RESHAPE_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog driving err.
module reshape_cmd_issuer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    output logic [3:0]  Control_Reshape,
    input  logic [7:0]  State,
    input  logic        Next_Reg,
    output logic        irq,
    input  logic        irq_clr,
    output logic        busy,
    output logic [15:0] done_cnt,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, ISSUE, RUN, IRQ, RELEASE} state_t;

    state_t      fsm_state, state_nxt;
    logic [3:0]  ctrl_q, ctrl_nxt;
    logic        irq_q, irq_nxt;
    logic [15:0] done_q, done_nxt;

`ifdef RESHAPE_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic        err_q, err_nxt;
    logic [31:0] tmo_q, tmo_nxt;
`else
    // The watchdog limit has no effect when the watchdog is not built.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_nxt = fsm_state;
        ctrl_nxt  = ctrl_q;
        irq_nxt   = irq_q;
        done_nxt  = done_q;
`ifdef RESHAPE_TIMEOUT_EN
        err_nxt   = err_q;
        tmo_nxt   = '0;
`endif
        case (fsm_state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ISSUE;
                    ctrl_nxt  = 4'b0001 << cmd_op;
`ifdef RESHAPE_TIMEOUT_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                // ctrl_q still holds the issued one-hot code here
                if (State == {4'h0, ctrl_q}) begin
                    state_nxt = RUN;
                    ctrl_nxt  = 4'h0;
                end
            end
            RUN: begin
                if (State == 8'h0F) begin
                    state_nxt = IRQ;
                    irq_nxt   = 1'b1;
                end
            end
            IRQ: begin
                if (irq_clr) begin
                    irq_nxt = 1'b0;
`ifdef RESHAPE_TIMEOUT_EN
                    // A timed-out operation skips the release handshake
                    if (err_q) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RELEASE;
                        ctrl_nxt  = 4'hF;
                    end
`else
                    state_nxt = RELEASE;
                    ctrl_nxt  = 4'hF;
`endif
                end
            end
            RELEASE: begin
                if (Next_Reg) begin
                    state_nxt = IDLE;
                    ctrl_nxt  = 4'h0;
                    done_nxt  = done_q + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ctrl_nxt  = 4'h0;
                irq_nxt   = 1'b0;
            end
        endcase
`ifdef RESHAPE_TIMEOUT_EN
        // Count only while stalled in a waiting state; any transition restarts it.
        if (state_nxt == fsm_state &&
            (fsm_state == ISSUE || fsm_state == RUN || fsm_state == RELEASE)) begin
            if (tmo_q == TMO_LAST) begin
                state_nxt = IRQ;
                ctrl_nxt  = 4'h0;
                irq_nxt   = 1'b1;
                err_nxt   = 1'b1;
            end else begin
                tmo_nxt = tmo_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state <= IDLE;
            ctrl_q    <= 4'h0;
            irq_q     <= 1'b0;
            done_q    <= 16'h0000;
`ifdef RESHAPE_TIMEOUT_EN
            err_q     <= 1'b0;
            tmo_q     <= '0;
`endif
        end else begin
            fsm_state <= state_nxt;
            ctrl_q    <= ctrl_nxt;
            irq_q     <= irq_nxt;
            done_q    <= done_nxt;
`ifdef RESHAPE_TIMEOUT_EN
            err_q     <= err_nxt;
            tmo_q     <= tmo_nxt;
`endif
        end
    end

    assign cmd_ready       = (fsm_state == IDLE);
    assign busy            = (fsm_state != IDLE);
    assign Control_Reshape = ctrl_q;
    assign irq             = irq_q;
    assign done_cnt        = done_q;
`ifdef RESHAPE_TIMEOUT_EN
    assign err             = err_q;
`else
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_reshape_cmd_issuer.sv
// tb/tb_reshape_cmd_issuer.sv - self-checking bench for reshape_cmd_issuer
module tb_reshape_cmd_issuer;
`ifdef RESHAPE_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic [3:0]  Control_Reshape;
    logic [7:0]  State;
    logic        Next_Reg;
    logic        irq;
    logic        irq_clr;
    logic        busy;
    logic [15:0] done_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reshape_cmd_issuer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .Control_Reshape(Control_Reshape), .State(State),
        .Next_Reg(Next_Reg), .irq(irq), .irq_clr(irq_clr), .busy(busy),
        .done_cnt(done_cnt), .err(err)
    );

    typedef struct {
        bit        r;
        bit        v;
        bit [1:0]  op;
        bit [7:0]  st;
        bit        nr;
        bit        ic;
        bit [3:0]  c;
        bit        i;
        bit        b;
        bit [15:0] d;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] c, input logic i,
                           input logic b, input logic [15:0] d, input logic e);
        chk({tag, "_ctrl"},  32'(Control_Reshape), 32'(c));
        chk({tag, "_irq"},   32'(irq),             32'(i));
        chk({tag, "_busy"},  32'(busy),            32'(b));
        chk({tag, "_ready"}, 32'(cmd_ready),       32'(!b));
        chk({tag, "_done"},  32'(done_cnt),        32'(d));
        chk({tag, "_err"},   32'(err),             32'(e));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input bit r, input bit v, input logic [1:0] op,
                        input logic [7:0] st, input bit nr, input bit ic);
        @(negedge clk);
        rst = r; cmd_valid = v; cmd_op = op; State = st; Next_Reg = nr; irq_clr = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] d0, input string tag);
        logic [3:0]  oh;
        logic [15:0] d1;
        oh = 4'b0001 << op;
        d1 = d0 + 16'd1;
        step(0, 1, op, 8'h00, 0, 0);        chk_out({tag, "_acc"},  oh,   0, 1, d0, 0);
        step(0, 0, 2'd0, {4'h0, oh}, 0, 0); chk_out({tag, "_iss"},  4'h0, 0, 1, d0, 0);
        step(0, 0, 2'd0, 8'h0F, 0, 0);      chk_out({tag, "_run"},  4'h0, 1, 1, d0, 0);
        step(0, 0, 2'd0, 8'h00, 0, 1);      chk_out({tag, "_clr"},  4'hF, 0, 1, d0, 0);
        step(0, 0, 2'd0, 8'h00, 1, 0);      chk_out({tag, "_rel"},  4'h0, 0, 0, d1, 0);
    endtask

    // Reference model: operation phase 0 idle, 1 issuing, 2 running, 3 interrupting, 4 releasing.
    int         m_ph;
    int         m_cnt;
    logic [1:0] m_op;
    logic [15:0] m_done;
    bit         m_err;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; State = 8'h00; Next_Reg = 1'b0; irq_clr = 1'b0;

        //        r  v  op  State  nr ic  ctrl  irq busy done
        tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 16'd0};
        tbl[1]  = '{0, 0, 0, 8'h00, 1, 1, 4'h0, 0, 0, 16'd0};
        tbl[2]  = '{0, 1, 2, 8'h00, 0, 0, 4'h4, 0, 1, 16'd0};
        tbl[3]  = '{0, 0, 0, 8'h02, 0, 0, 4'h4, 0, 1, 16'd0};
        tbl[4]  = '{0, 0, 0, 8'h04, 0, 0, 4'h0, 0, 1, 16'd0};
        tbl[5]  = '{0, 1, 0, 8'h00, 0, 1, 4'h0, 0, 1, 16'd0};
        tbl[6]  = '{0, 1, 1, 8'h04, 1, 1, 4'h0, 0, 1, 16'd0};
        tbl[7]  = '{0, 1, 3, 8'h0F, 0, 0, 4'h0, 1, 1, 16'd0};
        tbl[8]  = '{0, 1, 0, 8'h0F, 1, 0, 4'h0, 1, 1, 16'd0};
        tbl[9]  = '{0, 0, 0, 8'h00, 0, 1, 4'hF, 0, 1, 16'd0};
        tbl[10] = '{0, 1, 0, 8'h0F, 0, 1, 4'hF, 0, 1, 16'd0};
        tbl[11] = '{0, 0, 0, 8'h00, 1, 0, 4'h0, 0, 0, 16'd1};
        tbl[12] = '{0, 0, 0, 8'h00, 1, 1, 4'h0, 0, 0, 16'd1};

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].r, tbl[k].v, tbl[k].op, tbl[k].st, tbl[k].nr, tbl[k].ic);
            chk_out($sformatf("tbl%0d", k), tbl[k].c, tbl[k].i, tbl[k].b, tbl[k].d, 0);
        end

        // Reset during RELEASE with 1111 driven; rst wins over Next_Reg and cmd_valid.
        step(0, 1, 2'd3, 8'h00, 0, 0); chk_out("rr_acc", 4'h8, 0, 1, 16'd1, 0);
        step(0, 0, 2'd0, 8'h08, 0, 0); chk_out("rr_iss", 4'h0, 0, 1, 16'd1, 0);
        step(0, 0, 2'd0, 8'h0F, 0, 0); chk_out("rr_run", 4'h0, 1, 1, 16'd1, 0);
        step(0, 0, 2'd0, 8'h00, 0, 1); chk_out("rr_clr", 4'hF, 0, 1, 16'd1, 0);
        step(1, 1, 2'd1, 8'h0F, 1, 1); chk_out("rr_rst", 4'h0, 0, 0, 16'd0, 0);

        // Four back-to-back operations, each accepted on the first idle cycle.
        for (int k = 0; k < 4; k++)
            run_op(2'(k), 16'(k), $sformatf("b2b%0d", k));
        chk("b2b_done", 32'(done_cnt), 32'd4);

        // done_cnt wrap from 0xFFFF.
        @(negedge clk);
        force dut.done_q = 16'hFFFF;
        step(0, 0, 2'd0, 8'h00, 0, 0);
        release dut.done_q;
        step(0, 0, 2'd0, 8'h00, 0, 0);
        chk("wrap_pre", 32'(done_cnt), 32'hFFFF);
        run_op(2'd2, 16'hFFFF, "wrap");
        chk("wrap_zero", 32'(done_cnt), 32'h0000);

`ifdef RESHAPE_TIMEOUT_EN
        // Watchdog: State never answers the split code.
        step(1, 0, 2'd0, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 0, 0); chk_out("to_acc", 4'h2, 0, 1, 16'd0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 2'd0, 8'h00, 0, 0);
            if (k < 16) chk_out($sformatf("to_wait%0d", k), 4'h2, 0, 1, 16'd0, 0);
            else        chk_out("to_fire", 4'h0, 1, 1, 16'd0, 1);
        end
        step(0, 0, 2'd0, 8'h00, 0, 1); chk_out("to_clr", 4'h0, 0, 0, 16'd0, 1);
        step(0, 1, 2'd0, 8'h00, 0, 0); chk_out("to_new", 4'h1, 0, 1, 16'd0, 0);
`endif

        // Randomized run against the phase model.
        m_ph = 0; m_cnt = 0; m_op = 2'd0; m_done = 16'd0; m_err = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit         r, v, nr, ic;
            logic [1:0] op;
            logic [7:0] st;
            int         sel, nph;
            logic [3:0] ec;
            r   = (n == 0) || ($urandom_range(63) == 0);
            v   = 1'($urandom_range(1));
            op  = 2'($urandom_range(3));
            nr  = ($urandom_range(2) == 0);
            ic  = ($urandom_range(2) == 0);
            sel = $urandom_range(3);
            case (sel)
                0:       st = {4'h0, 4'b0001 << $urandom_range(3)};
                1:       st = 8'h0F;
                2:       st = 8'($urandom);
                default: st = {4'h0, 4'b0001 << m_op};
            endcase

            if (r) begin
                m_ph = 0; m_cnt = 0; m_done = 16'd0; m_err = 1'b0;
            end else begin
                nph = m_ph;
                case (m_ph)
                    0: if (v) begin nph = 1; m_op = op; m_err = 1'b0; end
                    1: if (st == {4'h0, 4'b0001 << m_op}) nph = 2;
                    2: if (st == 8'h0F) nph = 3;
                    3: if (ic) nph = m_err ? 0 : 4;
                    default: if (nr) begin nph = 0; m_done = m_done + 16'd1; end
                endcase
`ifdef RESHAPE_TIMEOUT_EN
                if (nph == m_ph && (m_ph == 1 || m_ph == 2 || m_ph == 4)) begin
                    if (m_cnt == TMO - 1) begin
                        nph = 3; m_err = 1'b1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_cnt = 0;
                end
`endif
                m_ph = nph;
            end

            step(r, v, op, st, nr, ic);
            ec = (m_ph == 1) ? (4'b0001 << m_op) : (m_ph == 4) ? 4'hF : 4'h0;
            chk_out($sformatf("rnd%0d", n), ec, (m_ph == 3), (m_ph != 0), m_done, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
